// File: rtl/keypad_entry_if.sv
// Keypad entry bundle: raw key/mode/card inputs toward the block and its registered results back.
interface keypad_entry_if;
  logic        key_press;
  logic [3:0]  key_code;
  logic        modo_monto;
  logic        tarjeta_recibida;
  logic [3:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic        desborde;

  modport master (
    output key_press, key_code, modo_monto, tarjeta_recibida,
    input  digito, digito_stb, monto, monto_stb, desborde
  );

  modport slave (
    input  key_press, key_code, modo_monto, tarjeta_recibida,
    output digito, digito_stb, monto, monto_stb, desborde
  );
endinterface

// File: rtl/keypad_entry.sv
// Keypad entry: forwards PIN digits (1 cycle) or accumulates up to 9-digit amounts, committed 2 cycles after ENTER.
// KEYPAD_BACKSPACE_EN makes CLEAR drop the last digit instead of wiping the whole amount.
module keypad_entry (
  input  logic          clk,
  input  logic          rst,
  keypad_entry_if.slave kp
);
  typedef enum logic [1:0] {IDLE, ACUM, EMITIR} state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        press_q;
  logic        armed_q;
  logic        modo_q;
  logic [3:0]  digito_q, digito_d;
  logic        digito_stb_q, digito_stb_d;
  logic [31:0] monto_q, monto_d;
  logic        monto_stb_q, monto_stb_d;
  logic        desborde_q, desborde_d;

  logic key_ev, is_digit, is_enter, is_clear, mode_chg;

  // armed_q blocks a key that was already down when reset released
  assign key_ev   = kp.key_press & ~press_q & armed_q;
  assign is_digit = (kp.key_code <= 4'd9);
  assign is_enter = (kp.key_code == 4'hA);
  assign is_clear = (kp.key_code == 4'hB);
  assign mode_chg = (kp.modo_monto != modo_q);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    digito_d     = digito_q;
    digito_stb_d = 1'b0;
    monto_d      = monto_q;
    monto_stb_d  = 1'b0;
    desborde_d   = 1'b0;

    if (kp.tarjeta_recibida || mode_chg) begin
      state_d = IDLE;
      acc_d   = 32'd0;
      cnt_d   = 4'd0;
    end else if (state_q == EMITIR) begin
      monto_d     = acc_q;
      monto_stb_d = 1'b1;
      acc_d       = 32'd0;
      cnt_d       = 4'd0;
      state_d     = IDLE;
    end else if (key_ev) begin
      if (!kp.modo_monto) begin
        if (is_digit) begin
          digito_d     = kp.key_code;
          digito_stb_d = 1'b1;
        end
      end else if (is_digit) begin
        // 9-digit cap keeps acc below 10^9, so the 32-bit product never wraps
        if (cnt_q < 4'd9) begin
          acc_d   = acc_q * 32'd10 + {28'd0, kp.key_code};
          cnt_d   = cnt_q + 4'd1;
          state_d = ACUM;
        end else begin
          desborde_d = 1'b1;
        end
      end else if (is_enter) begin
        if (state_q == ACUM) state_d = EMITIR;
      end else if (is_clear) begin
`ifdef KEYPAD_BACKSPACE_EN
        if (cnt_q != 4'd0) begin
          acc_d = acc_q / 32'd10;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = IDLE;
        end
`else
        acc_d   = 32'd0;
        cnt_d   = 4'd0;
        state_d = IDLE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      acc_q        <= 32'd0;
      cnt_q        <= 4'd0;
      press_q      <= 1'b0;
      armed_q      <= 1'b0;
      modo_q       <= kp.modo_monto;
      digito_q     <= 4'd0;
      digito_stb_q <= 1'b0;
      monto_q      <= 32'd0;
      monto_stb_q  <= 1'b0;
      desborde_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      press_q      <= kp.key_press;
      armed_q      <= armed_q | ~kp.key_press;
      modo_q       <= kp.modo_monto;
      digito_q     <= digito_d;
      digito_stb_q <= digito_stb_d;
      monto_q      <= monto_d;
      monto_stb_q  <= monto_stb_d;
      desborde_q   <= desborde_d;
    end
  end

  assign kp.digito     = digito_q;
  assign kp.digito_stb = digito_stb_q;
  assign kp.monto      = monto_q;
  assign kp.monto_stb  = monto_stb_q;
  assign kp.desborde   = desborde_q;
endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-low (rst=0 resets on the next rising clk edge).
REQ-003 The block SHALL have the port key_press, input, 1 bit: raw key-down level, held for the whole press.
REQ-004 The block SHALL have the port key_code, input, 4 bits: 0-9 is a decimal digit, 4'hA is ENTER, 4'hB is CLEAR, 4'hC-4'hF are ignored.
REQ-005 The block SHALL have the port modo_monto, input, 1 bit: 0 means PIN mode (forward digits), 1 means amount mode (accumulate).
REQ-006 The block SHALL have the port tarjeta_recibida, input, 1 bit: new-card pulse; aborts any entry in progress.
REQ-007 The block SHALL have the port digito, output, 4 bits: last forwarded PIN digit, held.
REQ-008 The block SHALL have the port digito_stb, output, 1 bit: one-cycle strobe marking digito valid.
REQ-009 The block SHALL have the port monto, output, 32 bits: last committed amount, held until the next commit.
REQ-010 The block SHALL have the port monto_stb, output, 1 bit: one-cycle strobe marking monto valid.
REQ-011 The block SHALL have the port desborde, output, 1 bit: one-cycle pulse marking a rejected digit.
REQ-012 All outputs SHALL be registered.

Function
REQ-013 A key event SHALL be accepted only on the cycle where key_press=1 and its registered previous value=0; a held key yields exactly one event.
REQ-014 The block SHALL keep the state machine {IDLE, ACUM, EMITIR}, a 32-bit accumulator acc and a 4-bit digit counter cnt.
REQ-015 In PIN mode, an accepted digit SHALL set digito=key_code and assert digito_stb on the cycle after acceptance (latency 1); ENTER and CLEAR SHALL be ignored; acc, cnt and the state SHALL stay unchanged.
REQ-016 In amount mode from IDLE or ACUM, an accepted digit d with cnt<9 SHALL set acc=acc*10+d and cnt=cnt+1, and move the state to ACUM.
REQ-017 In amount mode, an accepted digit with cnt=9 SHALL leave acc and cnt unchanged and pulse desborde one cycle later; because of the 9-digit limit (max 999999999), acc can never overflow 32 bits.
REQ-018 In amount mode, ENTER in ACUM SHALL move the state to EMITIR; in EMITIR, monto=acc and monto_stb=1 for exactly one cycle, then acc=0, cnt=0 and the state returns to IDLE; commit latency is 2 cycles from acceptance.
REQ-019 In amount mode, ENTER in IDLE (cnt=0) SHALL be ignored, with no strobe.
REQ-020 In amount mode, CLEAR SHALL follow REQ-030/REQ-031; when the result is cnt=0 the state SHALL move to IDLE.
REQ-021 Key events arriving while in EMITIR SHALL be dropped.
REQ-022 A change of modo_monto SHALL clear acc and cnt and move the state to IDLE on the same edge; any key event in that cycle SHALL be dropped.
REQ-023 tarjeta_recibida=1 SHALL clear acc and cnt and move the state to IDLE; it has priority over a simultaneous key event (the event is dropped) and over EMITIR (no monto_stb is issued).
REQ-024 Codes 4'hC-4'hF SHALL have no effect in any mode.

Reset
REQ-025 While rst=0 at a clk edge, the block SHALL set state=IDLE, acc=0, cnt=0, the previous key_press register=0, digito=0, digito_stb=0, monto=0, monto_stb=0 and desborde=0.
REQ-026 Reset during ACUM or EMITIR SHALL discard the pending amount with no strobe; reset has priority over every other input.
REQ-027 A key held through the release of reset SHALL NOT produce an event until it is released and pressed again.

Configuration
REQ-028 The macro KEYPAD_BACKSPACE_EN SHALL select the CLEAR behaviour.
REQ-029 This macro SHALL be the only compile-time option.
REQ-030 With KEYPAD_BACKSPACE_EN defined, CLEAR SHALL remove the last digit: acc=acc/10 and cnt=cnt-1 (no effect when cnt=0).
REQ-031 Without KEYPAD_BACKSPACE_EN, CLEAR SHALL set acc=0 and cnt=0.

Verification
REQ-032 The bench SHALL cover PIN forwarding: modo_monto=0, press 4,7,5,6 (each held 3 cycles) -> exactly 4 digito_stb pulses with digito=4,7,5,6 and monto_stb never asserted.
REQ-033 The bench SHALL cover amount commit: modo_monto=1, press 1,0,0,0,0 then ENTER -> a single monto_stb with monto=10000, 2 cycles after ENTER acceptance, and monto held afterwards.
REQ-034 The bench SHALL cover digit overflow: modo_monto=1, press ten 9s then ENTER -> desborde pulses once on the 10th digit, and monto=999999999.
REQ-035 The bench SHALL cover CLEAR: press 1,2,3, CLEAR, 4, ENTER -> monto=124 with the macro defined, monto=4 without it.
REQ-036 The bench SHALL cover the abort paths: press 5,5 then pulse tarjeta_recibida together with ENTER -> no monto_stb; a subsequent 7 then ENTER gives monto=7.
REQ-037 The bench SHALL cover reset mid-entry: press 8,8, assert rst=0 for 1 cycle while the key is held -> all outputs are 0, and there is no event until the key is released and pressed again.
